// File: rtl/exe_pkg.sv
// exe_pkg: shared constants for the exe_stage_mc execute stage.
// Opcodes, shift kinds, forwarding selects, flag indices, MUL FSM states.
package exe_pkg;

    localparam logic [3:0] OP_MOV = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_ADC = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_SBC = 4'b0101;
    localparam logic [3:0] OP_AND = 4'b0110;
    localparam logic [3:0] OP_ORR = 4'b0111;
    localparam logic [3:0] OP_EOR = 4'b1000;
    localparam logic [3:0] OP_MVN = 4'b1001;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    localparam logic [1:0] FWD_REG  = 2'b00;
    localparam logic [1:0] FWD_MEM  = 2'b01;
    localparam logic [1:0] FWD_WB   = 2'b10;
    localparam logic [1:0] FWD_REG2 = 2'b11;

    localparam int SR_N = 3;
    localparam int SR_Z = 2;
    localparam int SR_C = 1;
    localparam int SR_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/exe_mul_iter.sv
// exe_mul_iter: iterative radix-2^MUL_BITS shift-add multiplier.
// start_i retires the first digit; done_o marks the final digit's cycle.
module exe_mul_iter #(
    parameter int DATA_W   = 32,
    parameter int MUL_BITS = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] prod_o
);

    localparam int STEPS = DATA_W / MUL_BITS;
    localparam int CNT_W = $clog2(STEPS + 1);

    logic              busy_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] mcand_q;
    logic [DATA_W-1:0] mplier_q;

    function automatic logic [DATA_W-1:0] digit(
        input logic [DATA_W-1:0]   m,
        input logic [MUL_BITS-1:0] d
    );
        logic [DATA_W-1:0] r;
        r = '0;
        for (int i = 0; i < MUL_BITS; i++)
            if (d[i]) r = r + (m << i);
        return r;
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (abort_i) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (start_i) begin
            acc_q    <= digit(a_i, b_i[MUL_BITS-1:0]);
            mcand_q  <= a_i << MUL_BITS;
            mplier_q <= b_i >> MUL_BITS;
            cnt_q    <= CNT_W'(STEPS - 1);
            busy_q   <= (STEPS > 1);
        end else if (busy_q) begin
            acc_q    <= acc_q + digit(mcand_q, mplier_q[MUL_BITS-1:0]);
            mcand_q  <= mcand_q << MUL_BITS;
            mplier_q <= mplier_q >> MUL_BITS;
            cnt_q    <= cnt_q - CNT_W'(1);
            busy_q   <= (cnt_q != CNT_W'(1));
        end
    end

    assign busy_o = busy_q;
    assign done_o = busy_q & (cnt_q == CNT_W'(1));
    assign prod_o = acc_q;

endmodule

// File: rtl/exe_stage_mc.sv
// exe_stage_mc: registered ARM-subset execute stage with iterative MUL.
// Define EXE_FWD_EN to enable the MEM/WB operand forwarding muxes.
module exe_stage_mc
    import exe_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int IMM_W    = 24,
    parameter int REG_W    = 4,
    parameter int MUL_BITS = 2,
    parameter int BR_SHIFT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [IMM_W-1:0]  signed_immediate,
    input  logic [3:0]        EX_command,
    input  logic              is_mul,
    input  logic              S_in,
    input  logic [3:0]        SR_in,
    input  logic [11:0]       shifter_operand,
    input  logic [REG_W-1:0]  dst_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic              imm,
    input  logic              WB_en_in,
    input  logic              B_in,
    input  logic [DATA_W-1:0] val_Rn_in,
    input  logic [DATA_W-1:0] val_Rm_in,
    input  logic [1:0]        sel_src1,
    input  logic [1:0]        sel_src2,
    input  logic [DATA_W-1:0] MEM_stage_val,
    input  logic [DATA_W-1:0] WB_stage_val,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [REG_W-1:0]  dst_out,
    output logic [3:0]        SR_out,
    output logic              SR_update,
    output logic [DATA_W-1:0] ALU_res,
    output logic [DATA_W-1:0] val_Rm_out,
    output logic [DATA_W-1:0] branch_address,
    output logic [DATA_W-1:0] pc_out,
    output logic              mem_read_out,
    output logic              mem_write_out,
    output logic              WB_en_out,
    output logic              B_out,
    output logic              mul_busy
);

    localparam int STEPS = DATA_W / MUL_BITS;

    logic [DATA_W-1:0] op1, op2, val2, alu_res, br_addr;
    logic [DATA_W-1:0] b_op, mul_prod;
    logic [DATA_W:0]   sum;
    logic [31:0]       rot_amt, sh_amt;
    logic [3:0]        alu_sr, mul_sr;
    logic              arith, ci, alu_c, alu_v, alu_def;
    logic              accept, out_free, load_alu, load_mul;
    logic              mul_start, mul_abort, mul_done, mul_run;
    mul_state_e        state_q, state_d;
    logic              out_valid_q, out_valid_d;

    logic [DATA_W-1:0] res_q, rm_q, br_q, pc_q;
    logic [REG_W-1:0]  dst_q;
    logic [3:0]        sr_q;
    logic              mr_q, mw_q, wb_q, b_q, s_q;

    logic [DATA_W-1:0] m_rm_q, m_br_q, m_pc_q;
    logic [REG_W-1:0]  m_dst_q;
    logic [1:0]        m_cv_q;
    logic              m_mr_q, m_mw_q, m_wb_q, m_b_q, m_s_q;

`ifdef EXE_FWD_EN
    always_comb begin
        unique case (sel_src1)
            FWD_MEM: op1 = MEM_stage_val;
            FWD_WB:  op1 = WB_stage_val;
            default: op1 = val_Rn_in;
        endcase
        unique case (sel_src2)
            FWD_MEM: op2 = MEM_stage_val;
            FWD_WB:  op2 = WB_stage_val;
            default: op2 = val_Rm_in;
        endcase
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{sel_src1, sel_src2, MEM_stage_val, WB_stage_val};
    assign op1 = val_Rn_in;
    assign op2 = val_Rm_in;
`endif

    function automatic logic [DATA_W-1:0] ror(
        input logic [DATA_W-1:0] x,
        input logic [31:0]       s
    );
        return (x >> s) | (x << (32'(DATA_W) - s));
    endfunction

    always_comb begin
        rot_amt = (32'(shifter_operand[11:8]) << 1) % 32'(DATA_W);
        sh_amt  = 32'(shifter_operand[11:7]) % 32'(DATA_W);
        val2    = '0;
        if (mem_read_in | mem_write_in) begin
            val2 = DATA_W'(shifter_operand);
        end else if (imm) begin
            val2 = ror(DATA_W'(shifter_operand[7:0]), rot_amt);
        end else begin
            unique case (shifter_operand[6:5])
                SH_LSL:  val2 = op2 << sh_amt;
                SH_LSR:  val2 = op2 >> sh_amt;
                SH_ASR:  val2 = $unsigned($signed(op2) >>> sh_amt);
                default: val2 = ror(op2, sh_amt);
            endcase
        end
    end

    // Subtraction is op1 + ~val2 + carry-in, so C means "no borrow".
    always_comb begin
        arith   = 1'b0;
        b_op    = val2;
        ci      = 1'b0;
        alu_def = 1'b1;
        alu_res = '0;
        unique case (EX_command)
            OP_ADD: arith = 1'b1;
            OP_ADC: begin arith = 1'b1; ci = SR_in[SR_C]; end
            OP_SUB: begin arith = 1'b1; b_op = ~val2; ci = 1'b1; end
            OP_SBC: begin arith = 1'b1; b_op = ~val2; ci = SR_in[SR_C]; end
            default: ;
        endcase
        sum   = {1'b0, op1} + {1'b0, b_op} + {{DATA_W{1'b0}}, ci};
        alu_c = SR_in[SR_C];
        alu_v = SR_in[SR_V];
        unique case (EX_command)
            OP_MOV: alu_res = val2;
            OP_MVN: alu_res = ~val2;
            OP_AND: alu_res = op1 & val2;
            OP_ORR: alu_res = op1 | val2;
            OP_EOR: alu_res = op1 ^ val2;
            OP_ADD, OP_ADC, OP_SUB, OP_SBC: alu_res = sum[DATA_W-1:0];
            default: alu_def = 1'b0;
        endcase
        if (arith) begin
            alu_c = sum[DATA_W];
            alu_v = (op1[DATA_W-1] == b_op[DATA_W-1]) &
                    (alu_res[DATA_W-1] != op1[DATA_W-1]);
        end
        if (alu_def)
            alu_sr = {alu_res[DATA_W-1], alu_res == '0, alu_c, alu_v};
        else
            alu_sr = SR_in;
    end

    assign br_addr  = pc_in + (DATA_W'($signed(signed_immediate)) << BR_SHIFT);
    assign mul_busy = (state_q != ST_IDLE) | mul_run;
    assign out_free = !out_valid_q | out_ready;
    assign in_ready = !mul_busy & out_free;
    assign accept   = in_valid & in_ready & !flush;
    assign load_alu = accept & !is_mul;
    assign load_mul = (state_q == ST_DONE) & !flush & out_free;
    assign mul_sr   = {mul_prod[DATA_W-1], mul_prod == '0, m_cv_q};

    exe_mul_iter #(
        .DATA_W  (DATA_W),
        .MUL_BITS(MUL_BITS)
    ) u_mul (
        .clk_i  (clk),
        .rst_i  (rst),
        .start_i(mul_start),
        .abort_i(mul_abort),
        .a_i    (op1),
        .b_i    (op2),
        .busy_o (mul_run),
        .done_o (mul_done),
        .prod_o (mul_prod)
    );

    always_comb begin
        state_d   = state_q;
        mul_start = 1'b0;
        mul_abort = 1'b0;
        unique case (state_q)
            ST_IDLE: if (accept & is_mul) begin
                mul_start = 1'b1;
                state_d   = (STEPS == 1) ? ST_DONE : ST_ITER;
            end
            ST_ITER: if (flush) begin
                mul_abort = 1'b1;
                state_d   = ST_IDLE;
            end else if (mul_done) begin
                state_d = ST_DONE;
            end
            ST_DONE: if (flush | out_free) begin
                mul_abort = flush;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        if (flush)
            out_valid_d = 1'b0;
        else if (load_alu | load_mul)
            out_valid_d = 1'b1;
        else if (out_ready)
            out_valid_d = 1'b0;
        else
            out_valid_d = out_valid_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_rm_q  <= '0;
            m_br_q  <= '0;
            m_pc_q  <= '0;
            m_dst_q <= '0;
            m_cv_q  <= '0;
            m_mr_q  <= 1'b0;
            m_mw_q  <= 1'b0;
            m_wb_q  <= 1'b0;
            m_b_q   <= 1'b0;
            m_s_q   <= 1'b0;
        end else if (mul_start) begin
            m_rm_q  <= op2;
            m_br_q  <= br_addr;
            m_pc_q  <= pc_in;
            m_dst_q <= dst_in;
            m_cv_q  <= SR_in[SR_C:SR_V];
            m_mr_q  <= mem_read_in;
            m_mw_q  <= mem_write_in;
            m_wb_q  <= WB_en_in;
            m_b_q   <= B_in;
            m_s_q   <= S_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q <= '0;
            rm_q  <= '0;
            br_q  <= '0;
            pc_q  <= '0;
            dst_q <= '0;
            sr_q  <= '0;
            mr_q  <= 1'b0;
            mw_q  <= 1'b0;
            wb_q  <= 1'b0;
            b_q   <= 1'b0;
            s_q   <= 1'b0;
        end else if (load_alu) begin
            res_q <= alu_res;
            rm_q  <= op2;
            br_q  <= br_addr;
            pc_q  <= pc_in;
            dst_q <= dst_in;
            sr_q  <= alu_sr;
            mr_q  <= mem_read_in;
            mw_q  <= mem_write_in;
            wb_q  <= WB_en_in;
            b_q   <= B_in;
            s_q   <= S_in;
        end else if (load_mul) begin
            res_q <= mul_prod;
            rm_q  <= m_rm_q;
            br_q  <= m_br_q;
            pc_q  <= m_pc_q;
            dst_q <= m_dst_q;
            sr_q  <= mul_sr;
            mr_q  <= m_mr_q;
            mw_q  <= m_mw_q;
            wb_q  <= m_wb_q;
            b_q   <= m_b_q;
            s_q   <= m_s_q;
        end
    end

    assign out_valid      = out_valid_q;
    assign ALU_res        = res_q;
    assign val_Rm_out     = rm_q;
    assign branch_address = br_q;
    assign pc_out         = pc_q;
    assign dst_out        = dst_q;
    assign SR_out         = sr_q;
    assign SR_update      = s_q & out_valid_q;
    assign mem_read_out   = mr_q;
    assign mem_write_out  = mw_q;
    assign WB_en_out      = wb_q;
    assign B_out          = b_q;

endmodule

// File: tb/tb_exe_stage_mc.sv
// tb_exe_stage_mc: directed self-checking bench for exe_stage_mc.
// Expected values are hand-computed per step; build with EXE_FWD_EN to cover forwarding.
module tb_exe_stage_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, flush;
    logic [31:0] pc_in;
    logic [23:0] signed_immediate;
    logic [3:0]  EX_command;
    logic        is_mul, S_in;
    logic [3:0]  SR_in;
    logic [11:0] shifter_operand;
    logic [3:0]  dst_in;
    logic        mem_read_in, mem_write_in, imm, WB_en_in, B_in;
    logic [31:0] val_Rn_in, val_Rm_in;
    logic [1:0]  sel_src1, sel_src2;
    logic [31:0] MEM_stage_val, WB_stage_val;
    logic        out_ready, out_valid;
    logic [3:0]  dst_out, SR_out;
    logic        SR_update;
    logic [31:0] ALU_res, val_Rm_out, branch_address, pc_out;
    logic        mem_read_out, mem_write_out, WB_en_out, B_out, mul_busy;

    int errors = 0;
    int checks = 0;
    int busy_cnt, bad_cnt, guard;

    exe_stage_mc dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .flush           (flush),
        .pc_in           (pc_in),
        .signed_immediate(signed_immediate),
        .EX_command      (EX_command),
        .is_mul          (is_mul),
        .S_in            (S_in),
        .SR_in           (SR_in),
        .shifter_operand (shifter_operand),
        .dst_in          (dst_in),
        .mem_read_in     (mem_read_in),
        .mem_write_in    (mem_write_in),
        .imm             (imm),
        .WB_en_in        (WB_en_in),
        .B_in            (B_in),
        .val_Rn_in       (val_Rn_in),
        .val_Rm_in       (val_Rm_in),
        .sel_src1        (sel_src1),
        .sel_src2        (sel_src2),
        .MEM_stage_val   (MEM_stage_val),
        .WB_stage_val    (WB_stage_val),
        .out_ready       (out_ready),
        .out_valid       (out_valid),
        .dst_out         (dst_out),
        .SR_out          (SR_out),
        .SR_update       (SR_update),
        .ALU_res         (ALU_res),
        .val_Rm_out      (val_Rm_out),
        .branch_address  (branch_address),
        .pc_out          (pc_out),
        .mem_read_out    (mem_read_out),
        .mem_write_out   (mem_write_out),
        .WB_en_out       (WB_en_out),
        .B_out           (B_out),
        .mul_busy        (mul_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_in();
        in_valid = 0; flush = 0; is_mul = 0; S_in = 0; SR_in = 0;
        imm = 0; mem_read_in = 0; mem_write_in = 0; WB_en_in = 0; B_in = 0;
        EX_command = 0; shifter_operand = 0; dst_in = 0;
        val_Rn_in = 0; val_Rm_in = 0; sel_src1 = 0; sel_src2 = 0;
        MEM_stage_val = 0; WB_stage_val = 0; pc_in = 0; signed_immediate = 0;
    endtask

    task automatic op(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] rm,
                      input logic [11:0] sh, input logic im, input logic s);
        idle_in();
        in_valid = 1; EX_command = cmd; val_Rn_in = rn; val_Rm_in = rm;
        shifter_operand = sh; imm = im; S_in = s;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; out_ready = 1;
        idle_in();
        repeat (2) tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_res", ALU_res, 0);
        chk("rst_sr", SR_out, 0);
        chk("rst_busy", mul_busy, 0);
        chk("rst_ready", in_ready, 1);
        rst = 0;
        tick();

        op(4'b0010, 10, 0, 12'h005, 1, 0); dst_in = 3; WB_en_in = 1;
        chk("add_in_ready", in_ready, 1);
        tick();
        chk("add_valid", out_valid, 1);
        chk("add_res", ALU_res, 15);
        chk("add_sr", SR_out, 4'b0000);
        chk("add_dst", dst_out, 3);
        chk("add_wb", WB_en_out, 1);
        chk("add_srupd", SR_update, 0);
        idle_in();
        tick();
        chk("out_clear", out_valid, 0);

        op(4'b0100, 3, 3, 12'h000, 0, 1);
        tick();
        chk("sub_res", ALU_res, 0);
        chk("sub_sr", SR_out, 4'b0110);
        chk("sub_srupd", SR_update, 1);

        op(4'b0010, 32'h7FFF_FFFF, 1, 12'h000, 0, 1);
        tick();
        chk("addv_res", ALU_res, 32'h8000_0000);
        chk("addv_sr", SR_out, 4'b1001);

        op(4'b0101, 5, 3, 12'h000, 0, 1);
        tick();
        chk("sbc_res", ALU_res, 1);
        chk("sbc_sr", SR_out, 4'b0010);

        op(4'b0001, 0, 32'h8000_0001, 12'h240, 0, 0);
        tick();
        chk("asr_res", ALU_res, 32'hF800_0000);

        op(4'b0001, 0, 32'h8000_0001, 12'h260, 0, 1); SR_in = 4'b0011;
        tick();
        chk("ror_res", ALU_res, 32'h1800_0000);
        chk("ror_sr", SR_out, 4'b0011);

        op(4'b0001, 0, 0, 12'h1FF, 1, 0);
        tick();
        chk("immrot_res", ALU_res, 32'hC000_003F);

        op(4'b0010, 32'h1000, 32'hABCD, 12'hFFF, 0, 0); mem_write_in = 1;
        tick();
        chk("mem_res", ALU_res, 32'h1FFF);
        chk("mem_wr", mem_write_out, 1);
        chk("mem_rm", val_Rm_out, 32'hABCD);

        op(4'b0000, 5, 5, 12'h000, 0, 1); SR_in = 4'b1010;
        tick();
        chk("undef_res", ALU_res, 0);
        chk("undef_sr", SR_out, 4'b1010);

        op(4'b1000, 32'hF0F0, 32'hFF00, 12'h000, 0, 0);
        tick();
        chk("eor_res", ALU_res, 32'h0FF0);

        op(4'b1001, 0, 0, 12'h000, 0, 1);
        tick();
        chk("mvn_res", ALU_res, 32'hFFFF_FFFF);
        chk("mvn_sr", SR_out, 4'b1000);

        op(4'b0010, 20, 1, 12'h000, 0, 0);
        sel_src1 = 2'b01; MEM_stage_val = 100; sel_src2 = 2'b10; WB_stage_val = 7;
        tick();
`ifdef EXE_FWD_EN
        chk("fwd_res", ALU_res, 107);
        chk("fwd_rm", val_Rm_out, 7);
`else
        chk("fwd_res", ALU_res, 21);
        chk("fwd_rm", val_Rm_out, 1);
`endif

        op(4'b0001, 0, 0, 12'h000, 0, 0);
        B_in = 1; pc_in = 32'h100; signed_immediate = 24'hFF_FFFF;
        tick();
        chk("br_addr", branch_address, 32'hFC);
        chk("br_pc", pc_out, 32'h100);
        chk("br_b", B_out, 1);

        op(4'b0010, 1, 1, 12'h000, 0, 0); flush = 1;
        tick();
        chk("flush_in_valid", out_valid, 0);

        op(4'b0010, 1, 0, 12'h002, 1, 0);
        tick();
        chk("bp_first", ALU_res, 3);
        op(4'b0010, 50, 0, 12'h002, 1, 0);
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_res", ALU_res, 3);
            chk("bp_hold_ready", in_ready, 0);
        end
        out_ready = 1;
        #1;
        chk("bp_release_ready", in_ready, 1);
        tick();
        chk("bp_next_res", ALU_res, 52);
        idle_in();
        tick();

        op(4'b0000, 7, 6, 12'h000, 0, 0); is_mul = 1; dst_in = 5;
        tick();
        idle_in();
        busy_cnt = 0; bad_cnt = 0; guard = 0;
        while (!out_valid && guard < 40) begin
            if (mul_busy) begin
                busy_cnt++;
                if (in_ready) bad_cnt++;
            end
            tick();
            guard++;
        end
        chk("mul_timeout", out_valid, 1);
        chk("mul_busy_cycles", busy_cnt, 16);
        chk("mul_ready_low", bad_cnt, 0);
        chk("mul_res", ALU_res, 42);
        chk("mul_dst", dst_out, 5);
        chk("mul_busy_end", mul_busy, 0);
        tick();

        op(4'b0000, 9, 9, 12'h000, 0, 0); is_mul = 1;
        tick();
        idle_in();
        repeat (4) tick();
        chk("mflush_busy_before", mul_busy, 1);
        flush = 1;
        tick();
        flush = 0;
        chk("mflush_busy_after", mul_busy, 0);
        chk("mflush_ready", in_ready, 1);
        bad_cnt = 0;
        for (int i = 0; i < 25; i++) begin
            if (out_valid) bad_cnt++;
            tick();
        end
        chk("mflush_no_out", bad_cnt, 0);

        op(4'b0000, 3, 3, 12'h000, 0, 0); is_mul = 1;
        tick();
        idle_in();
        repeat (3) tick();
        rst = 1;
        #1;
        chk("mrst_busy", mul_busy, 0);
        chk("mrst_valid", out_valid, 0);
        #1;
        rst = 0;
        bad_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) bad_cnt++;
            tick();
        end
        chk("mrst_no_out", bad_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exe_stage_mc.md
Name: exe_stage_mc

Overview:
Parametrised, registered execute stage for the ARM-subset pipeline, sitting between the ID/EX register and the memory stage.
- Computes the shifter operand (Val2), ALU result, NZCV flags and branch target, then drives them through an internal EX/MEM output register.
- Adds a valid/ready handshake, flush, operand forwarding and an iterative multi-cycle MUL that back-pressures the front end.

Parameters:
DATA_W, 32, datapath width (even, >=8)
IMM_W, 24, branch immediate width
REG_W, 4, register index width
MUL_BITS, 2, multiplier bits retired per cycle (must divide DATA_W)
BR_SHIFT, 2, left shift applied to the sign-extended branch immediate

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  ID/EX holds an instruction
in_ready  out  1  stage accepts this cycle
flush  in  1  kill in-flight and output instruction
pc_in  in  DATA_W  pc of instruction
signed_immediate  in  IMM_W  branch offset
EX_command  in  4  ALU opcode
is_mul  in  1  instruction is MUL
S_in  in  1  update status register
SR_in  in  4  current {N,Z,C,V}
shifter_operand  in  12  ARM shifter field
dst_in  in  REG_W  destination register
mem_read_in, mem_write_in, imm, WB_en_in, B_in  in  1 each  control
val_Rn_in, val_Rm_in  in  DATA_W  register values
sel_src1, sel_src2  in  2  forwarding selects
MEM_stage_val, WB_stage_val  in  DATA_W  forwarded values
out_ready  in  1  memory stage accepts
out_valid  out  1  output register valid
dst_out  out  REG_W  ; SR_out out 4 ; SR_update out 1 (S_in & valid)
ALU_res, val_Rm_out, branch_address, pc_out  out  DATA_W each
mem_read_out, mem_write_out, WB_en_out, B_out  out  1 each
mul_busy  out  1  multiplier iterating

Behaviour:
- Reset: all outputs and the FSM clear to 0/IDLE; SR_out = 4'b0000.
- Forwarding: op1/op2 = 00 reg value, 01 MEM_stage_val, 10 WB_stage_val, 11 reg value. op1 derives from Rn, op2 from Rm. val_Rm_out = forwarded op2 (store data).
- Val2:
  - mem access: zero-extended shifter_operand[11:0].
  - imm=1: 8-bit imm rotated right by 2*rot mod DATA_W.
  - else: op2 shifted by shifter_operand[6:5] (LSL/LSR/ASR/ROR), amount [11:7] mod DATA_W.
- ALU opcodes:
  - 0001 MOV, 1001 MVN, 0010 ADD, 0011 ADC, 0100 SUB, 0101 SBC, 0110 AND, 0111 ORR, 1000 EOR.
  - Undefined opcodes give 0 and leave flags unchanged.
- Flags:
  - N = msb, Z = (res == 0).
  - C/V computed for arithmetic ops only; logic ops pass C and V from SR_in.
  - SBC uses op1 - val2 - !C.
- branch_address = pc_in + (sext(signed_immediate) << BR_SHIFT), truncated to DATA_W.
- in_ready = !mul_busy & (!out_valid | out_ready). Accept = in_valid & in_ready & !flush.
- Non-MUL: latency 1; the output register loads on accept.
- MUL FSM:
  - IDLE -> ITER on accept with is_mul; operands and control are latched.
  - ITER runs DATA_W/MUL_BITS cycles; result is the low DATA_W bits of op1*op2.
  - ITER -> DONE; DONE loads the output register when (!out_valid | out_ready), then returns to IDLE.
  - Flags: N,Z from the product; C,V from SR_in.
- Output hold: while out_valid & !out_ready, every output is stable.
- Output clear: if out_ready and nothing new loads, out_valid drops to 0.
- flush: same-cycle priority over accept and DONE. It clears out_valid, aborts the FSM to IDLE and deasserts mul_busy next cycle.
- Reset mid-MUL: immediate return to IDLE with no output.

Optional Feature:
EXE_FWD_EN
- Defined: forwarding muxes active as above.
- Undefined: sel_src1/sel_src2/MEM_stage_val/WB_stage_val are ignored; op1 = val_Rn_in and op2 = val_Rm_in directly.

Decomposition:
- Package exe_pkg holds:
  - the ALU opcode localparams;
  - shift-type codes;
  - FSM state enum (IDLE, ITER, DONE);
  - forwarding select codes;
  - SR bit indices (N=3, Z=2, C=1, V=0).
- One sub-module, exe_mul_iter: start/busy/done handshake, radix-2^MUL_BITS shift-add, abort input.
- Val2 and ALU stay combinational inside the top.

Test Plan:
- ADD, imm=1, rot=0, imm8=5, Rn=10 -> next cycle ALU_res=15, SR_out=0000, out_valid=1.
- SUB with Rn=3, val2=3, S_in=1 -> ALU_res=0, SR_out Z=1, C=1, SR_update=1.
- MUL 7*6, MUL_BITS=2 -> mul_busy for 16 cycles, in_ready=0 throughout, then ALU_res=42.
- sel_src1=01, MEM_stage_val=100, ADD Rm=1 (LSL 0) -> ALU_res=101; with EXE_FWD_EN undefined -> Rn+1.
- out_ready=0 for 3 cycles after a result -> outputs frozen and in_ready=0; release -> next instruction loads.
- flush in cycle 5 of MUL -> mul_busy=0 next cycle, out_valid never asserts; branch with pc=0x100 and imm=-1 gives branch_address=0xFC.
